// File: rtl/mp_pkg.sv
// Shared constants and helpers for the multi-precision carry-save accumulator.
// Contents:
//   MP_WIDTH, MP_SEGMENTS, MP_SEG_W  datapath geometry (operand, segment count, segment width)
//   MP_ACC_W, MP_PAD_W, MP_IDX_W     derived widths
//   RES_SEG0..RES_SEG4, RES_IDLE     resolve select codes
//   mp_acc_t, mp_op_t                accumulator / operand vector types
//   mp_maj                           bitwise majority used by the carry-save step
package mp_pkg;

  localparam int unsigned MP_WIDTH    = 514;
  localparam int unsigned MP_SEGMENTS = 5;
  localparam int unsigned MP_ACC_W    = MP_WIDTH + 1;
  localparam int unsigned MP_SEG_W    = (MP_ACC_W + MP_SEGMENTS - 1) / MP_SEGMENTS;
  localparam int unsigned MP_PAD_W    = MP_SEGMENTS * MP_SEG_W;
  localparam int unsigned MP_IDX_W    = $clog2(MP_SEGMENTS);

  localparam logic [3:0] RES_SEG0 = 4'd0;
  localparam logic [3:0] RES_SEG1 = 4'd1;
  localparam logic [3:0] RES_SEG2 = 4'd2;
  localparam logic [3:0] RES_SEG3 = 4'd3;
  localparam logic [3:0] RES_SEG4 = 4'd4;
  localparam logic [3:0] RES_IDLE = 4'd8;

  typedef logic [MP_ACC_W-1:0] mp_acc_t;
  typedef logic [MP_WIDTH-1:0] mp_op_t;

  function automatic mp_op_t mp_maj(mp_op_t a, mp_op_t b, mp_op_t c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mp_adder_if.sv
// Control/data bundle for mp_adder.
// Signals:
//   in_a              operand (MP_WIDTH bits)
//   subtract          accumulate -in_a instead of +in_a
//   shift             with enableC, shift the step result right by one
//   enableC           carry-save accumulate strobe
//   showFluffyPonies  resolve select code (0..MP_SEGMENTS-1 resolve, others hold)
//   trueResult        sum register (MP_WIDTH+1 bits)
//   cZero             carry register is all zero
// Modports: master drives the controls, slave is the accumulator side.
interface mp_adder_if;
  import mp_pkg::*;

  logic [MP_WIDTH-1:0] in_a;
  logic                subtract;
  logic                shift;
  logic                enableC;
  logic [3:0]          showFluffyPonies;
  logic [MP_WIDTH:0]   trueResult;
  logic                cZero;

  modport master (
    output in_a, subtract, shift, enableC, showFluffyPonies,
    input  trueResult, cZero
  );

  modport slave (
    input  in_a, subtract, shift, enableC, showFluffyPonies,
    output trueResult, cZero
  );
endinterface

// File: rtl/mp_seg_adder.sv
// One carry-propagate segment: o_sum/o_cout = i_a + i_b + i_cin.
// Ports:
//   i_a, i_b  SegW-bit addends
//   i_cin     carry in
//   o_sum     SegW-bit sum
//   o_cout    carry out
module mp_seg_adder #(
  parameter int unsigned SegW = 103
) (
  input  logic [SegW-1:0] i_a,
  input  logic [SegW-1:0] i_b,
  input  logic            i_cin,
  output logic [SegW-1:0] o_sum,
  output logic            o_cout
);

  logic [SegW:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SegW{1'b0}}, i_cin};
  assign {o_cout, o_sum} = w_full;

endmodule

// File: rtl/mp_adder.sv
// Carry-save multi-precision accumulator with segmented carry-propagate resolve.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset (clears S, C and the segment carry)
//   bus     mp_adder_if.slave: operand/control inputs, trueResult and cZero outputs
// Each enableC cycle folds +/-in_a into the redundant pair (S, C), optionally halving.
// Without enableC, codes 0..MP_SEGMENTS-1 resolve one segment of S+C into S and clear
// that segment of C, chaining the carry through r_k; other codes hold.
// Build option MPADDER_CZERO_REG_EN: cZero becomes a register loaded from the next C
// (reset value 1); otherwise it is decoded combinationally from the C register.
module mp_adder
  import mp_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mp_adder_if.slave   bus
);

  mp_acc_t r_s;
  mp_acc_t r_c;
  logic    r_k;

  mp_acc_t w_s_nxt;
  mp_acc_t w_c_nxt;
  logic    w_k_nxt;

  // Carry-save step
  mp_acc_t w_a;
  mp_acc_t w_sx;
  mp_acc_t w_cx;

  always_comb begin
    w_a  = bus.subtract ? ~{1'b0, bus.in_a} : {1'b0, bus.in_a};
    w_sx = r_s ^ r_c ^ w_a;
    // The majority MSB would land above the register and is discarded; the freed LSB
    // slot takes the +1 that completes the two's complement negation.
    w_cx = {mp_maj(r_s[MP_WIDTH-1:0], r_c[MP_WIDTH-1:0], w_a[MP_WIDTH-1:0]), bus.subtract};
  end

  // Resolve segment select and writeback
  logic                w_seg_vld;
  logic [MP_IDX_W-1:0] w_seg_idx;
  logic [MP_PAD_W-1:0] w_s_pad;
  logic [MP_PAD_W-1:0] w_c_pad;
  logic [MP_PAD_W-1:0] w_s_res;
  logic [MP_PAD_W-1:0] w_c_res;
  logic [MP_SEG_W-1:0] w_seg_s;
  logic [MP_SEG_W-1:0] w_seg_c;
  logic [MP_SEG_W-1:0] w_seg_sum;
  logic                w_seg_cin;
  logic                w_seg_co;

  assign w_seg_vld = (bus.showFluffyPonies < 4'(MP_SEGMENTS));
  assign w_seg_idx = bus.showFluffyPonies[MP_IDX_W-1:0];
  assign w_seg_cin = (w_seg_idx == '0) ? 1'b0 : r_k;

  always_comb begin
    w_s_pad = '0;
    w_c_pad = '0;
    w_s_pad[MP_ACC_W-1:0] = r_s;
    w_c_pad[MP_ACC_W-1:0] = r_c;
    w_seg_s = '0;
    w_seg_c = '0;
    for (int unsigned j = 0; j < MP_SEGMENTS; j++) begin
      if (w_seg_idx == MP_IDX_W'(j)) begin
        w_seg_s = w_s_pad[j*MP_SEG_W +: MP_SEG_W];
        w_seg_c = w_c_pad[j*MP_SEG_W +: MP_SEG_W];
      end
    end
  end

  mp_seg_adder #(
    .SegW (MP_SEG_W)
  ) u_seg_adder (
    .i_a    (w_seg_s),
    .i_b    (w_seg_c),
    .i_cin  (w_seg_cin),
    .o_sum  (w_seg_sum),
    .o_cout (w_seg_co)
  );

  always_comb begin
    w_s_res = w_s_pad;
    w_c_res = w_c_pad;
    for (int unsigned j = 0; j < MP_SEGMENTS; j++) begin
      if (w_seg_idx == MP_IDX_W'(j)) begin
        w_s_res[j*MP_SEG_W +: MP_SEG_W] = w_seg_sum;
        w_c_res[j*MP_SEG_W +: MP_SEG_W] = '0;
      end
    end
  end

  // Next state: enableC > resolve code > hold
  always_comb begin
    w_s_nxt = r_s;
    w_c_nxt = r_c;
    w_k_nxt = r_k;
    if (bus.enableC) begin
      if (bus.shift) begin
        w_s_nxt = w_sx >> 1;
        w_c_nxt = w_cx >> 1;
      end else begin
        w_s_nxt = w_sx;
        w_c_nxt = w_cx;
      end
    end else if (w_seg_vld) begin
      // Anything above MP_ACC_W in the last segment, and its carry, falls off here.
      w_s_nxt = w_s_res[MP_ACC_W-1:0];
      w_c_nxt = w_c_res[MP_ACC_W-1:0];
      w_k_nxt = w_seg_co;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s <= '0;
      r_c <= '0;
      r_k <= 1'b0;
    end else begin
      r_s <= w_s_nxt;
      r_c <= w_c_nxt;
      r_k <= w_k_nxt;
    end
  end

  assign bus.trueResult = r_s;

`ifdef MPADDER_CZERO_REG_EN
  logic r_czero;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_czero <= 1'b1;
    end else begin
      r_czero <= ~|w_c_nxt;
    end
  end

  assign bus.cZero = r_czero;
`else
  assign bus.cZero = ~|r_c;
`endif

endmodule

// File: tb/tb_mp_adder.sv
// Self-checking bench for mp_adder: directed vector table, hand-written corner
// sequences and randomized accumulate/resolve runs against a plain-integer model.
module tb_mp_adder;
  import mp_pkg::*;

  localparam int unsigned W  = MP_WIDTH;
  localparam int unsigned AW = MP_ACC_W;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  mp_adder_if bus();

  mp_adder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string name, input mp_acc_t act, input mp_acc_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply one cycle of controls; returns 1 time unit after the edge.
  task automatic drive(input logic en, input logic sub, input logic sh,
                       input logic [W-1:0] a, input logic [3:0] code);
    bus.enableC          = en;
    bus.subtract         = sub;
    bus.shift            = sh;
    bus.in_a             = a;
    bus.showFluffyPonies = code;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enableC          = 1'b0;
    bus.subtract         = 1'b0;
    bus.shift            = 1'b0;
    bus.in_a             = '0;
    bus.showFluffyPonies = RES_IDLE;
  endtask

  task automatic acc(input logic [W-1:0] a, input logic sub, input logic sh);
    drive(1'b1, sub, sh, a, RES_IDLE);
  endtask

  task automatic resolve();
    for (int j = 0; j < int'(MP_SEGMENTS); j++) begin
      drive(1'b0, 1'b0, 1'b0, '0, 4'(j));
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) begin
      t[i*32 +: 32] = $urandom;
    end
    return t[W-1:0];
  endfunction

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_sub;
    logic         mid_chk;
    logic         mid_cz;
    mp_acc_t      exp;
  } vec_t;

  vec_t tbl[6];

  mp_acc_t      all1;
  logic [W-1:0] ones;
  mp_acc_t      model;
  logic [W-1:0] n_val;
  logic [W-1:0] r_a;
  logic [519:0] wide;
  logic [AW:0]  sum_sh;

  initial begin
    all1 = '1;
    ones = '1;
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_result", bus.trueResult, '0);
    check_bit("reset_czero", bus.cZero, 1'b1);
    resetn = 1'b1;

    repeat (3) drive(1'b0, 1'b0, 1'b0, ones, RES_IDLE);
    check_val("hold8_result", bus.trueResult, '0);
    check_bit("hold8_czero", bus.cZero, 1'b1);

    // Directed vectors: add a, then add/subtract b, then resolve.
    tbl[0] = '{a: W'(3), b: W'(3), b_sub: 1'b0, mid_chk: 1'b0, mid_cz: 1'b0, exp: AW'(6)};
    tbl[1] = '{a: W'(5), b: W'(7), b_sub: 1'b1, mid_chk: 1'b0, mid_cz: 1'b0,
               exp: all1 - AW'(1)};
    tbl[2] = '{a: ones, b: ones, b_sub: 1'b0, mid_chk: 1'b1, mid_cz: 1'b0,
               exp: all1 - AW'(1)};
    tbl[3] = '{a: W'(0), b: W'(1), b_sub: 1'b1, mid_chk: 1'b0, mid_cz: 1'b0, exp: all1};
    tbl[4] = '{a: ones, b: W'(0), b_sub: 1'b1, mid_chk: 1'b0, mid_cz: 1'b0,
               exp: {1'b0, ones}};
    tbl[5] = '{a: W'(1) << 513, b: W'(1) << 513, b_sub: 1'b0, mid_chk: 1'b0, mid_cz: 1'b0,
               exp: AW'(1) << 514};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      acc(tbl[i].a, 1'b0, 1'b0);
      acc(tbl[i].b, tbl[i].b_sub, 1'b0);
      if (tbl[i].mid_chk) begin
        check_bit($sformatf("vec%0d_mid_czero", i), bus.cZero, tbl[i].mid_cz);
      end
      idle_inputs();
      resolve();
      check_val($sformatf("vec%0d_result", i), bus.trueResult, tbl[i].exp);
      check_bit($sformatf("vec%0d_czero", i), bus.cZero, 1'b1);
    end

    // 3,3,0,N,N,N then +1 with halving. Bits 512:511 of N are cleared so 3N+7 stays
    // below 2^515 and the halving step is exact.
    do_reset();
    n_val = rand_op();
    n_val[513] = 1'b1;
    n_val[512] = 1'b0;
    n_val[511] = 1'b0;
    acc(W'(3), 1'b0, 1'b0);
    acc(W'(3), 1'b0, 1'b0);
    acc(W'(0), 1'b0, 1'b0);
    repeat (3) acc(n_val, 1'b0, 1'b0);
    acc(W'(1), 1'b0, 1'b1);
    idle_inputs();
    resolve();
    wide = 520'(n_val) * 520'd3 + 520'd7;
    check_val("three_n_shift", bus.trueResult, AW'(wide >> 1));
    check_bit("three_n_czero", bus.cZero, 1'b1);

    // Code 8 must hold a pending carry-save state untouched.
    do_reset();
    acc(W'(5), 1'b0, 1'b0);
    acc(W'(9), 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, ones, RES_IDLE);
    resolve();
    check_val("hold_then_resolve", bus.trueResult, AW'(14));

    // Reset in the middle of a resolve sequence.
    do_reset();
    acc(ones, 1'b0, 1'b0);
    acc(ones, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, RES_SEG0);
    drive(1'b0, 1'b0, 1'b0, '0, RES_SEG1);
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, RES_SEG2);
    resetn = 1'b1;
    check_val("midreset_result", bus.trueResult, '0);
    check_bit("midreset_czero", bus.cZero, 1'b1);
    idle_inputs();

    // Randomized runs: the model is the plain integer value mod 2^515. Halving is only
    // issued right after a resolve, where the carry register is empty.
    do_reset();
    model = '0;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        r_a = rand_op();
        acc(r_a, 1'b0, 1'b1);
        sum_sh = {1'b0, model} + {2'b00, r_a};
        model  = sum_sh[AW:1];
      end
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        r_a = rand_op();
        if ($urandom_range(0, 1) == 1) begin
          acc(r_a, 1'b1, 1'b0);
          model = model - {1'b0, r_a};
        end else begin
          acc(r_a, 1'b0, 1'b0);
          model = model + {1'b0, r_a};
        end
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'b0, 1'b0, rand_op(), RES_IDLE);
        end
      end
      idle_inputs();
      resolve();
      check_val($sformatf("rand%0d_result", it), bus.trueResult, model);
      check_bit($sformatf("rand%0d_czero", it), bus.cZero, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
